// File: rtl/teeter_pkg.sv
// Shared types and constants for the teeter board hole scanner.
package teeter_pkg;

    localparam int COORD_W = 10;  // pixel coordinate width
    localparam int SQ_W    = 20;  // square of one axis difference
    localparam int ACC_W   = 21;  // sum of two squares, cannot overflow

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SQX,
        ST_SQY,
        ST_CMP,
        ST_DONE
    } state_t;

    // Capture radius squared, sized to the accumulator for the compare
    function automatic logic [ACC_W-1:0] radius_sq(input int unsigned radius);
        return ACC_W'(radius * radius);
    endfunction

endpackage

// File: rtl/hole_scan_ctrl_if.sv
// Frame/ball/ROM/result signals between ball physics, hole ROM, game logic and the scanner.
interface hole_scan_ctrl_if #(
    parameter int NUM_HOLES = 8
) ();
    localparam int IW = $clog2(NUM_HOLES);

    logic          i_frame_tick;
    logic [9:0]    i_bl_x;
    logic [9:0]    i_bl_y;
    logic [IW-1:0] o_hole_idx;
    logic [9:0]    i_hole_pos_x;
    logic [9:0]    i_hole_pos_y;
    logic          o_busy;
    logic          o_done;
    logic          o_hit;
    logic [IW-1:0] o_hit_idx;
    logic          o_goal;

    // The scanner itself
    modport slave (
        input  i_frame_tick, i_bl_x, i_bl_y, i_hole_pos_x, i_hole_pos_y,
        output o_hole_idx, o_busy, o_done, o_hit, o_hit_idx, o_goal
    );

    // Whoever drives the frame tick, ball position and ROM data
    modport master (
        output i_frame_tick, i_bl_x, i_bl_y, i_hole_pos_x, i_hole_pos_y,
        input  o_hole_idx, o_busy, o_done, o_hit, o_hit_idx, o_goal
    );

endinterface

// File: rtl/hole_scan_ctrl_abs_diff_sq.sv
// Combinational |a-b|^2 on unsigned coordinates; the single shared squarer.
module abs_diff_sq
    import teeter_pkg::*;
(
    input  logic [COORD_W-1:0] a,
    input  logic [COORD_W-1:0] b,
    output logic [SQ_W-1:0]    sq
);

    logic [COORD_W-1:0] diff;
    logic [SQ_W-1:0]    diff_ext;

    // Absolute difference (never a wrapped subtraction), then square
    always_comb begin
        // NOTE: every signal written here gets a value on every path first, so no latch is inferred.
        diff     = '0;
        diff_ext = '0;
        sq       = '0;
        if (a >= b) begin
            diff = a - b;
        end else begin
            diff = b - a;
        end
        diff_ext = SQ_W'(diff);
        sq       = diff_ext * diff_ext;
    end

endmodule

// File: rtl/hole_scan_ctrl.sv
// Per-frame hole scanner: walks the hole table with one shared squarer and
// reports the first hole whose capture radius contains the ball.
module hole_scan_ctrl
    import teeter_pkg::*;
#(
    parameter int NUM_HOLES = 8,
    parameter int RADIUS    = 16,
    parameter int GOAL_IDX  = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    hole_scan_ctrl_if.slave  bus
);

    localparam int                IW       = $clog2(NUM_HOLES);
    localparam logic [ACC_W-1:0]  RAD_SQ   = radius_sq(RADIUS);
    localparam logic [IW-1:0]     LAST_IDX = IW'(NUM_HOLES - 1);
    localparam logic [IW-1:0]     GOAL     = IW'(GOAL_IDX);

    state_t             state;
    logic [COORD_W-1:0] ball_x;
    logic [COORD_W-1:0] ball_y;
    logic [IW-1:0]      idx;
    logic [SQ_W-1:0]    dxsq;
    logic [ACC_W-1:0]   acc;
    logic               busy;
    logic               done;
    logic               hit;
    logic [IW-1:0]      hit_idx;
    logic               goal;

    logic [COORD_W-1:0] op_a;
    logic [COORD_W-1:0] op_b;
    logic [SQ_W-1:0]    sq;

    // Squarer operand mux: Y pair during SQY, X pair otherwise
    always_comb begin
        op_a = ball_x;
        op_b = bus.i_hole_pos_x;
        if (state == ST_SQY) begin
            op_a = ball_y;
            op_b = bus.i_hole_pos_y;
        end
    end

    abs_diff_sq u_abs_diff_sq (
        .a  (op_a),
        .b  (op_b),
        .sq (sq)
    );

    // Scan FSM with registered outputs; reset aborts a scan and clears results
    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so every register sees pre-edge values.
        if (i_rst) begin
            state   <= ST_IDLE;
            ball_x  <= '0;
            ball_y  <= '0;
            idx     <= '0;
            dxsq    <= '0;
            acc     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hit     <= 1'b0;
            hit_idx <= '0;
            goal    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_frame_tick) begin
                        ball_x <= bus.i_bl_x;
                        ball_y <= bus.i_bl_y;
                        idx    <= '0;
                        busy   <= 1'b1;
                        state  <= ST_FETCH;
                    end
                end
                // ROM address is already idx; its data lands for SQX
                ST_FETCH: begin
                    state <= ST_SQX;
                end
                ST_SQX: begin
                    dxsq  <= sq;
                    state <= ST_SQY;
                end
                ST_SQY: begin
                    acc   <= ACC_W'(dxsq) + ACC_W'(sq);
                    state <= ST_CMP;
                end
                ST_CMP: begin
                    if (acc <= RAD_SQ) begin
                        hit     <= 1'b1;
                        hit_idx <= idx;
                        goal    <= (idx == GOAL);
                        done    <= 1'b1;
                        state   <= ST_DONE;
                    end else if (idx == LAST_IDX) begin
                        hit     <= 1'b0;
                        hit_idx <= '0;
                        goal    <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= ST_FETCH;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_hole_idx = idx;
    assign bus.o_busy     = busy;
    assign bus.o_done     = done;
    assign bus.o_hit      = hit;
    assign bus.o_hit_idx  = hit_idx;
    assign bus.o_goal     = goal;

endmodule

// File: tb/tb_hole_scan_ctrl.sv
// Directed self-checking bench for hole_scan_ctrl with a synchronous hole ROM model.
module tb_hole_scan_ctrl;

    localparam int NUM_HOLES = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fails  = 0;

    logic [9:0] tab_x [NUM_HOLES];
    logic [9:0] tab_y [NUM_HOLES];

    always #5 clk = ~clk;

    hole_scan_ctrl_if #(.NUM_HOLES(NUM_HOLES)) sif ();

    hole_scan_ctrl #(
        .NUM_HOLES (NUM_HOLES),
        .RADIUS    (16),
        .GOAL_IDX  (0)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (sif.slave)
    );

    // Synchronous hole ROM: data follows the address one clock later
    always @(posedge clk) begin
        sif.i_hole_pos_x <= tab_x[sif.o_hole_idx];
        sif.i_hole_pos_y <= tab_y[sif.o_hole_idx];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // All holes far (>= 400 px) from any ball position used below
    task automatic set_far();
        for (int i = 0; i < NUM_HOLES; i++) begin
            tab_x[i] = 10'(500 + i * 60);
            tab_y[i] = 10'd600;
        end
    endtask

    // Tick one scan, scramble the ball inputs afterwards, measure latency to o_done
    task automatic run_scan(input string tag, input logic [9:0] bx, input logic [9:0] by,
                            input int retick_at, input bit tick_in_done, input int exp_lat,
                            input logic exp_hit, input logic [2:0] exp_idx, input logic exp_goal);
        int lat;
        int extra_done;
        bit seen;
        @(negedge clk);
        sif.i_bl_x       = bx;
        sif.i_bl_y       = by;
        sif.i_frame_tick = 1'b1;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 200) begin
            @(negedge clk);
            lat++;
            sif.i_frame_tick = (lat == retick_at);
            if (lat == 1) begin
                sif.i_bl_x = ~bx;
                sif.i_bl_y = ~by;
                check({tag, "_busy"}, 32'(sif.o_busy), 32'd1);
                check({tag, "_rom_addr"}, 32'(sif.o_hole_idx), 32'd0);
            end
            if (sif.o_done === 1'b1) seen = 1'b1;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_hit"}, 32'(sif.o_hit), 32'(exp_hit));
        check({tag, "_hit_idx"}, 32'(sif.o_hit_idx), 32'(exp_idx));
        check({tag, "_goal"}, 32'(sif.o_goal), 32'(exp_goal));
        sif.i_frame_tick = tick_in_done;
        @(negedge clk);
        sif.i_frame_tick = 1'b0;
        check({tag, "_done_pulse"}, 32'(sif.o_done), 32'd0);
        check({tag, "_idle"}, 32'(sif.o_busy), 32'd0);
        check({tag, "_hit_held"}, 32'(sif.o_hit), 32'(exp_hit));
        // Make sure no second o_done shows up (catches queued ticks)
        extra_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sif.o_done === 1'b1) extra_done++;
        end
        check({tag, "_no_extra_done"}, 32'(extra_done), 32'd0);
    endtask

    initial begin
        int n_done;
        rst              = 1'b1;
        sif.i_frame_tick = 1'b0;
        sif.i_bl_x       = '0;
        sif.i_bl_y       = '0;
        set_far();
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(sif.o_busy), 32'd0);
        check("rst_done", 32'(sif.o_done), 32'd0);
        check("rst_hit", 32'(sif.o_hit), 32'd0);
        check("rst_hit_idx", 32'(sif.o_hit_idx), 32'd0);
        check("rst_goal", 32'(sif.o_goal), 32'd0);
        check("rst_rom_addr", 32'(sif.o_hole_idx), 32'd0);
        rst = 1'b0;

        // 1: no hole near the ball -> full table, 4*8+1 cycles
        run_scan("miss_all", 10'd100, 10'd100, 0, 1'b0, 33, 1'b0, 3'd0, 1'b0);

        // 2: hole 3 at (110,110), dist^2 = 200 -> 4*4+1 cycles
        tab_x[3] = 10'd110; tab_y[3] = 10'd110;
        run_scan("hit3", 10'd100, 10'd100, 0, 1'b0, 17, 1'b1, 3'd3, 1'b0);

        // 3: inclusive boundary at hole 5: 256 hits, 257 misses
        set_far();
        tab_x[5] = 10'd116; tab_y[5] = 10'd100;
        run_scan("edge_256", 10'd100, 10'd100, 0, 1'b0, 25, 1'b1, 3'd5, 1'b0);
        tab_y[5] = 10'd101;
        run_scan("edge_257", 10'd100, 10'd100, 0, 1'b0, 33, 1'b0, 3'd0, 1'b0);

        // 4: absolute difference, a wrapped subtraction would give dx=9
        tab_x[5] = 10'd1020; tab_y[5] = 10'd5;
        run_scan("no_wrap", 10'd5, 10'd5, 0, 1'b0, 33, 1'b0, 3'd0, 1'b0);
        tab_x[5] = 10'd10; tab_y[5] = 10'd0;
        run_scan("origin", 10'd0, 10'd0, 0, 1'b0, 25, 1'b1, 3'd5, 1'b0);

        // 5: holes 0 and 2 both cover the ball; lowest index (the goal) wins
        set_far();
        tab_x[0] = 10'd105; tab_y[0] = 10'd100;
        tab_x[2] = 10'd100; tab_y[2] = 10'd100;
        run_scan("goal", 10'd100, 10'd100, 0, 1'b0, 5, 1'b1, 3'd0, 1'b1);

        // 6a: retick mid-scan and tick during DONE are both ignored
        set_far();
        tab_x[3] = 10'd110; tab_y[3] = 10'd110;
        run_scan("retick", 10'd100, 10'd100, 3, 1'b1, 17, 1'b1, 3'd3, 1'b0);

        // 6b: reset in cycle 10 of a scan aborts it and clears the held hit
        @(negedge clk);
        sif.i_bl_x       = 10'd100;
        sif.i_bl_y       = 10'd100;
        sif.i_frame_tick = 1'b1;
        @(negedge clk);
        sif.i_frame_tick = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(sif.o_busy), 32'd0);
        check("abort_done", 32'(sif.o_done), 32'd0);
        check("abort_hit", 32'(sif.o_hit), 32'd0);
        check("abort_hit_idx", 32'(sif.o_hit_idx), 32'd0);
        check("abort_goal", 32'(sif.o_goal), 32'd0);
        check("abort_rom_addr", 32'(sif.o_hole_idx), 32'd0);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sif.o_done === 1'b1) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);

        // 6c: a fresh tick after reset scans normally
        run_scan("after_rst", 10'd100, 10'd100, 0, 1'b0, 17, 1'b1, 3'd3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/hole_scan_ctrl.md
Name: hole_scan_ctrl

Overview:
Per-frame scheduler that checks the ball position against every hole in the board's hole table. One shared abs-difference/squarer unit is time-multiplexed over X and Y and over all holes, instead of one distance checker per hole. The block sits between the ball-physics update (frame tick, ball coordinates) and the game-state logic, which consumes the hit/goal result. It also drives the address of the synchronous hole-position ROM.

Parameters:
NUM_HOLES, 8, number of entries in the hole table (must be ≥2); IW = $clog2(NUM_HOLES).
RADIUS, 16, capture radius in pixels; the capture test uses RADIUS*RADIUS as a 21-bit constant.
GOAL_IDX, 0, hole-table index of the goal hole (a win, not a fall).

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous, active-high reset
i_frame_tick  in  1  one-cycle pulse that starts a scan
i_bl_x  in  10  ball centre X, unsigned pixels
i_bl_y  in  10  ball centre Y, unsigned pixels
o_hole_idx  out  IW  hole ROM read address
i_hole_pos_x  in  10  hole centre X; valid one cycle after o_hole_idx changes
i_hole_pos_y  in  10  hole centre Y; same timing as i_hole_pos_x
o_busy  out  1  high while a scan is in progress
o_done  out  1  one-cycle pulse when a scan completes
o_hit  out  1  ball is inside some hole's radius
o_hit_idx  out  IW  index of the hit hole
o_goal  out  1  the hit hole is GOAL_IDX

Behaviour:
- Reset: state IDLE. All outputs 0: o_hole_idx, o_busy, o_done, o_hit, o_hit_idx, o_goal.
- A reset asserted mid-scan aborts the scan. No o_done is produced and the previous results are cleared.
- FSM states: IDLE, FETCH, SQX, SQY, CMP, DONE. All outputs are registered.
- IDLE:
  - On i_frame_tick, latch i_bl_x and i_bl_y into internal registers, set idx=0, go to FETCH.
  - The ball inputs are not sampled again during the scan.
- FETCH: o_hole_idx=idx. Go to SQX; the ROM data is valid from SQX onward and held stable through CMP.
- SQX: dxsq <= |bx - hx|^2. The difference is a 10-bit absolute value; the square is 20 bits. Go to SQY.
- SQY: acc <= dxsq + |by - hy|^2, a 21-bit sum that cannot overflow. Go to CMP.
- CMP:
  - If acc <= RADIUS*RADIUS (inclusive): o_hit<=1, o_hit_idx<=idx, o_goal<=(idx==GOAL_IDX), go to DONE.
  - Else if idx==NUM_HOLES-1: o_hit<=0, o_hit_idx<=0, o_goal<=0, go to DONE.
  - Else idx<=idx+1, go to FETCH.
- DONE: o_done=1 for exactly this cycle, then go to IDLE.
- o_busy=1 in every state except IDLE.
- Results (o_hit, o_hit_idx, o_goal) hold until the next CMP that terminates a scan.
- Latency from the tick cycle to o_done high:
  - no hit: 4*NUM_HOLES+1 cycles;
  - hit at index h: 4*(h+1)+1 cycles.
- Early exit on the first hit. If several holes overlap the ball, the lowest index wins.
- An i_frame_tick while o_busy=1 is ignored; nothing is queued.
- A tick in the same cycle as DONE is ignored. A tick in the next cycle (IDLE) starts a new scan.
- Coordinates use absolute unsigned difference, never a wrapped subtraction. Ball x=5 with hole x=1020 gives dx=1015.
- Exactly one squarer instance exists; SQX and SQY select its operands through a mux.

Decomposition:
- Shared package (teeter_pkg): FSM state enum; COORD_W=10, SQ_W=20, ACC_W=21; a function computing RADIUS*RADIUS at ACC_W width.
- One natural sub-module, abs_diff_sq: combinational, inputs two 10-bit operands, output 20-bit |a-b|^2. It is instantiated once, and its operands are muxed by state.

Test Plan:
1. NUM_HOLES=8, ball (100,100), all holes ≥200 px away, tick → o_busy rises; o_done 33 cycles after tick; o_hit=0, o_goal=0.
2. Hole 3 at (110,110), holes 0-2 far → dist²=200 ≤256; o_done 17 cycles after tick; o_hit=1, o_hit_idx=3, o_goal=0.
3. Boundary, single candidate at hole 5: hole at (116,100) → 256, hit. Hole at (116,101) → 257, no hit.
4. Wrap: ball (5,5), hole (1020,5) → no hit. Ball (0,0), hole (10,0) → hit with dx=10.
5. Holes 0 and 2 both cover the ball, GOAL_IDX=0 → o_hit_idx=0, o_goal=1, o_done at 5 cycles.
6. Second tick during a scan → ignored, a single o_done. Reset at cycle 10 of a scan → IDLE, outputs 0, no o_done. A tick after reset scans normally.
